// File: rtl/vga_scan_engine.sv
// VGA timing generator and image-buffer scanner: raster counters feed a
// 2-stage pipeline (read address/strobe, then pins). Optional colour-bar
// test pattern is enabled by defining VGA_TEST_PATTERN_EN.
module vga_scan_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int CW       = 4,
  parameter int AW       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              i_pattern,
`endif
  input  logic [3*CW-1:0]   i_pixel,
  output logic [AW-1:0]     o_addr,
  output logic              o_rd_en,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [CW-1:0]     o_red,
  output logic [CW-1:0]     o_green,
  output logic [CW-1:0]     o_blue,
  output logic              o_active,
  output logic              o_frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int HX = HW + 1;
  localparam int VX = VW + 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HX-1:0] H_ACT_X  = HX'(H_ACTIVE);
  localparam logic [VX-1:0] V_ACT_X  = VX'(V_ACTIVE);
  localparam logic [HX-1:0] HS_BEG_X = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] HS_END_X = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] VS_BEG_X = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] VS_END_X = VX'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HX-1:0] IMG_W_X  = HX'(IMG_W);
  localparam logic [VX-1:0] IMG_H_X  = VX'(IMG_H);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [HX-1:0] h_ext;
  logic [VX-1:0] v_ext;
  logic          h_wrap, v_wrap, at_origin;
  logic          in_img, in_act, in_hs, in_vs;
  logic          pat_now;

  always_comb begin
    h_ext     = {1'b0, h_cnt};
    v_ext     = {1'b0, v_cnt};
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    at_origin = (h_cnt == '0) && (v_cnt == '0);
    in_img    = (h_ext < IMG_W_X) && (v_ext < IMG_H_X);
    in_act    = (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
    in_hs     = (h_ext >= HS_BEG_X) && (h_ext < HS_END_X);
    in_vs     = (v_ext >= VS_BEG_X) && (v_ext < VS_END_X);
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  logic           pat_mode;
  logic [BPW-1:0] bar_pos;
  logic [2:0]     bar_idx;
  logic           s1_pat;
  logic [2:0]     s1_bar;

  // Mode latched at the origin so it applies to the whole frame, including (0,0) itself.
  assign pat_now = at_origin ? i_pattern : pat_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_mode <= 1'b0;
    end else if (en && at_origin) begin
      pat_mode <= i_pattern;
    end
  end

  // Bar index tracked alongside h_cnt to avoid a divider.
  always_ff @(posedge clk) begin
    if (rst || !en || h_wrap) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BAR_LAST) begin
      bar_pos <= '0;
      bar_idx <= bar_idx + 1'b1;
    end else begin
      bar_pos <= bar_pos + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_pat <= 1'b0;
      s1_bar <= '0;
    end else begin
      s1_pat <= en && pat_now;
      s1_bar <= bar_idx;
    end
  end
`else
  assign pat_now = 1'b0;
`endif

  logic s1_hs, s1_vs, s1_act, s1_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_act  <= 1'b0;
      s1_last <= 1'b0;
      o_rd_en <= 1'b0;
      o_addr  <= '0;
    end else begin
      s1_hs   <= en && in_hs;
      s1_vs   <= en && in_vs;
      s1_act  <= en && in_act;
      s1_last <= en && h_wrap && v_wrap;
      o_rd_en <= en && in_img && !pat_now;
      // Raster order makes the image address a running count of reads.
      if (en && at_origin) begin
        o_addr <= '0;
      end else if (en && in_img && !pat_now) begin
        o_addr <= o_addr + 1'b1;
      end
    end
  end

  logic [3*CW-1:0] rgb_next;

  always_comb begin
    rgb_next = '0;
    if (s1_act) begin
`ifdef VGA_TEST_PATTERN_EN
      if (s1_pat) begin
        rgb_next = {{CW{s1_bar[2]}}, {CW{s1_bar[1]}}, {CW{s1_bar[0]}}};
      end else if (o_rd_en) begin
        rgb_next = i_pixel;
      end
`else
      if (o_rd_en) begin
        rgb_next = i_pixel;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hsync      <= ~HS_ACT;
      o_vsync      <= ~VS_ACT;
      o_active     <= 1'b0;
      o_frame_done <= 1'b0;
      o_red        <= '0;
      o_green      <= '0;
      o_blue       <= '0;
    end else begin
      o_hsync      <= s1_hs ? HS_ACT : ~HS_ACT;
      o_vsync      <= s1_vs ? VS_ACT : ~VS_ACT;
      o_active     <= s1_act;
      o_frame_done <= s1_last;
      {o_red, o_green, o_blue} <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboard bench for vga_scan_engine: a raster model predicts stage-1 and
// pin values per clock; predictions are queued and compared as the DUT emits them.
module tb_vga_scan_engine;

  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int HS_POL   = 0;
  localparam int VS_POL   = 1;
  localparam int IMG_W    = 5;
  localparam int IMG_H    = 3;
  localparam int CW       = 4;
  localparam int AW       = 4;
  localparam int PW       = 3 * CW;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT       = H_TOTAL * V_TOTAL;
  localparam int BAR_W    = H_ACTIVE / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, i_pattern;
  logic [PW-1:0] i_pixel;
  logic [AW-1:0] o_addr;
  logic          o_rd_en, o_hsync, o_vsync, o_active, o_frame_done;
  logic [CW-1:0] o_red, o_green, o_blue;

  vga_scan_engine #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .CW(CW), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern(i_pattern),
`endif
    .i_pixel(i_pixel),
    .o_addr(o_addr),
    .o_rd_en(o_rd_en),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_red(o_red),
    .o_green(o_green),
    .o_blue(o_blue),
    .o_active(o_active),
    .o_frame_done(o_frame_done)
  );

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic          fd;
    logic [PW-1:0] rgb;
  } pins_t;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
  } s1_t;

  typedef struct {
    int unsigned n;
    bit          r;
    bit          e;
    bit          p;
  } phase_t;

  pins_t pq[$];
  s1_t   sq[$];

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   cyc   = 0;
  int            mh = 0, mv = 0;
  logic [AW-1:0] maddr = '0;
  bit            mpat = 1'b0;
  int unsigned   last_fd = 0;
  bit            fd_clean = 1'b0;

  localparam pins_t IDLE = '{hs: (HS_POL == 0), vs: (VS_POL == 0), act: 1'b0, fd: 1'b0, rgb: '0};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] mem_data(input int a);
    return PW'(a * 37 + 11);
  endfunction

  // Predicts stage-1 outputs after the coming edge and pins one edge later.
  task automatic model_step(input bit r, input bit e, input bit p);
    bit         valid, pat_now, origin, in_img, rd;
    logic [2:0] bar;
    pins_t      pn;
    valid   = e && !r;
    origin  = (mh == 0) && (mv == 0);
    pat_now = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
    pat_now = origin ? p : mpat;
    if (r) mpat = 1'b0;
    else if (valid && origin) mpat = p;
`endif
    in_img = (mh < IMG_W) && (mv < IMG_H);
    rd     = valid && in_img && !pat_now;
    if (r) maddr = '0;
    else if (valid && origin) maddr = '0;
    else if (rd) maddr = AW'(mv * IMG_W + mh);

    pn.hs  = (valid && mh >= H_ACTIVE + H_FP && mh < H_ACTIVE + H_FP + H_SYNC) ? (HS_POL != 0) : (HS_POL == 0);
    pn.vs  = (valid && mv >= V_ACTIVE + V_FP && mv < V_ACTIVE + V_FP + V_SYNC) ? (VS_POL != 0) : (VS_POL == 0);
    pn.act = valid && mh < H_ACTIVE && mv < V_ACTIVE;
    pn.fd  = valid && mh == H_TOTAL - 1 && mv == V_TOTAL - 1;
    pn.rgb = '0;
    if (pn.act) begin
      if (pat_now) begin
        bar    = 3'(mh / BAR_W);
        pn.rgb = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
      end else if (rd) begin
        pn.rgb = mem_data(mv * IMG_W + mh);
      end
    end

    if (r) begin
      pq.delete();
      pq.push_back(IDLE);
    end
    pq.push_back(pn);
    sq.push_back('{rd: rd, addr: maddr});

    if (!valid) begin
      mh = 0;
      mv = 0;
    end else if (mh == H_TOTAL - 1) begin
      mh = 0;
      mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic one_cycle(input bit r, input bit e, input bit p);
    pins_t ep;
    s1_t   es;
    @(negedge clk);
    cyc++;
    if (sq.size() > 0) begin
      es = sq.pop_front();
      check_val("rd_en", 32'(o_rd_en), 32'(es.rd));
      check_val("addr",  32'(o_addr),  32'(es.addr));
    end
    if (pq.size() > 0) begin
      ep = pq.pop_front();
      check_val("hsync",  32'(o_hsync),  32'(ep.hs));
      check_val("vsync",  32'(o_vsync),  32'(ep.vs));
      check_val("active", 32'(o_active), 32'(ep.act));
      check_val("fdone",  32'(o_frame_done), 32'(ep.fd));
      check_val("rgb",    32'({o_red, o_green, o_blue}), 32'(ep.rgb));
    end
    if (o_frame_done === 1'b1) begin
      if (fd_clean) check_val("fd_gap", cyc - last_fd, FT);
      last_fd  = cyc;
      fd_clean = 1'b1;
    end
    if (r || !e) fd_clean = 1'b0;
    rst       = r;
    en        = e;
    i_pattern = p;
    i_pixel   = (o_rd_en === 1'b1) ? mem_data(int'(o_addr)) : (PW'(12'hABC) ^ {PW{p}});
    model_step(r, e, p);
  endtask

  phase_t ph[7] = '{
    '{3,   1'b1, 1'b0, 1'b0},
    '{600, 1'b0, 1'b1, 1'b0},
    '{1,   1'b1, 1'b1, 1'b0},
    '{150, 1'b0, 1'b1, 1'b0},
    '{10,  1'b0, 1'b0, 1'b0},
    '{260, 1'b0, 1'b1, 1'b1},
    '{240, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    i_pattern = 1'b0;
    i_pixel   = '0;
    foreach (ph[k]) begin
      for (int unsigned i = 0; i < ph[k].n; i++) begin
        one_cycle(ph[k].r, ph[k].e, ph[k].p);
      end
    end
    for (int i = 0; i < 400; i++) begin
      one_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) begin
      one_cycle(1'b0, 1'b1, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
